i2s_sample_feeder: RTL and testbench

Rate-adapting sample buffer directly upstream of the MAX98357A I2S transmitter. Accepts 16-bit mono PCM samples in bursts over a valid/ready handshake, buffers them in a FIFO, and presents one sample per audio sample period on `left_data` / `data_valid`. Handles prefill, underrun recovery and optional attenuation. Underrun recovery outputs silence while the FIFO refills.

---
 rtl/i2s_sample_feeder_pkg.sv | 22 ++
 rtl/i2s_sample_feeder_if.sv | 11 +
 rtl/i2s_sample_feeder_fifo.sv | 50 +++++
 rtl/i2s_sample_feeder.sv | 121 ++++++++++++
 tb/tb_i2s_sample_feeder.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/i2s_sample_feeder_pkg.sv
// rtl/i2s_sample_feeder_pkg.sv - shared audio types and clock/rate defaults for the I2S feeder and transmitter
package audio_pkg;

   localparam int DEF_SAMPLE_RATE = 34375;
   localparam int DEF_CLK         = 44_000_000;
   localparam int DEF_DATA_WIDTH  = 16;

   typedef logic signed [DEF_DATA_WIDTH-1:0] sample_t;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      PLAY
   } feed_state_t;

   function automatic int sample_period(input int clk_hz, input int rate_hz);
      return clk_hz / rate_hz;
   endfunction

   localparam int SAMPLE_PERIOD = sample_period(DEF_CLK, DEF_SAMPLE_RATE);

endpackage

// File: rtl/i2s_sample_feeder_if.sv
// rtl/i2s_sample_feeder_if.sv - valid/ready sample stream into the feeder
interface i2s_sample_feeder_if #(
   parameter int DATA_WIDTH = 16
);
   logic [DATA_WIDTH-1:0] s_data;
   logic                  s_valid;
   logic                  s_ready;

   modport master (output s_data, output s_valid, input s_ready);
   modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/i2s_sample_feeder_fifo.sv
// rtl/i2s_sample_feeder_fifo.sv - single-clock first-word-fall-through FIFO with synchronous flush
module sync_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_flush,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [WIDTH-1:0]         i_data,
   output logic [WIDTH-1:0]         o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_do_push;
   logic             w_do_pop;

   // Extra pointer MSB separates full (MSBs differ) from empty (MSBs equal)
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_level   = r_wr_ptr - r_rd_ptr;
   assign o_data    = r_mem[r_rd_ptr[AW-1:0]];
   assign w_do_push = i_push && !o_full && !i_flush;
   assign w_do_pop  = i_pop && !o_empty && !i_flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/i2s_sample_feeder.sv
// rtl/i2s_sample_feeder.sv - rate-adapting sample buffer presenting one sample per audio period
module i2s_sample_feeder
   import audio_pkg::*;
#(
   parameter int SAMPLE_RATE = DEF_SAMPLE_RATE,
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int CLK         = DEF_CLK,
   parameter int FIFO_DEPTH  = 64,
   parameter int PREFILL     = 32
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          enable,
   i2s_sample_feeder_if.slave            s_if,
   input  logic [3:0]                    atten,
   output logic [DATA_WIDTH-1:0]         left_data,
   output logic                          data_valid,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [15:0]                   underrun_count
);
   localparam int PERIOD = sample_period(CLK, SAMPLE_RATE);
   localparam int CW     = $clog2(PERIOD);
   localparam int LW     = $clog2(FIFO_DEPTH) + 1;
   localparam logic [LW-1:0] PREFILL_LVL = LW'(PREFILL);

   logic [CW-1:0]         r_tick_cnt;
   logic                  w_tick;
   feed_state_t           r_state;
   feed_state_t           w_state_next;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_load;
   logic                  w_urun_inc;
   logic                  w_valid_next;
   logic [DATA_WIDTH-1:0] w_head;
   logic [DATA_WIDTH-1:0] w_data_next;

   assign w_tick      = (r_tick_cnt == CW'(PERIOD - 1));
   assign s_if.s_ready = enable && !w_full;
   assign w_push      = s_if.s_valid && s_if.s_ready;

   sync_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (reset_n),
      .i_flush (!enable),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (s_if.s_data),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (fifo_level)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_tick_cnt <= '0;
      else          r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_state_next;
   end

   // Outputs only move on a tick or on disable, so the transmitter sees a stable word all period
   always_comb begin
      w_state_next = r_state;
      w_pop        = 1'b0;
      w_load       = 1'b0;
      w_urun_inc   = 1'b0;
      w_valid_next = 1'b0;
      w_data_next  = '0;
      if (!enable) begin
         w_state_next = IDLE;
         w_load       = 1'b1;
      end else begin
         case (r_state)
            IDLE: w_state_next = FILL;
            FILL: begin
               w_load = w_tick;
               if (fifo_level >= PREFILL_LVL) w_state_next = PLAY;
            end
            PLAY: begin
               if (w_tick) begin
                  w_load = 1'b1;
                  if (!w_empty) begin
                     w_pop        = 1'b1;
                     w_valid_next = 1'b1;
                     w_data_next  = $signed(w_head) >>> atten;
                  end else begin
                     w_urun_inc   = 1'b1;
                     w_state_next = FILL;
                  end
               end
            end
            default: w_state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         left_data  <= '0;
         data_valid <= 1'b0;
      end else if (w_load) begin
         left_data  <= w_data_next;
         data_valid <= w_valid_next;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) underrun_count <= '0;
      else if (w_urun_inc && (underrun_count != 16'hFFFF)) underrun_count <= underrun_count + 1'b1;
   end

endmodule

// File: tb/tb_i2s_sample_feeder.sv
// tb/tb_i2s_sample_feeder.sv - randomized bench for i2s_sample_feeder against a queue-based reference
module tb_i2s_sample_feeder;
   import audio_pkg::*;

   localparam int P     = 32;
   localparam int DEPTH = 64;
   localparam int PRE   = 32;

   logic        clk;
   logic        reset_n;
   logic        enable;
   logic [3:0]  atten;
   logic [15:0] left_data;
   logic        data_valid;
   logic [6:0]  fifo_level;
   logic [15:0] underrun_count;

   i2s_sample_feeder_if #(.DATA_WIDTH(16)) sif ();

   i2s_sample_feeder #(
      .SAMPLE_RATE (1_375_000),
      .DATA_WIDTH  (16),
      .CLK         (44_000_000),
      .FIFO_DEPTH  (DEPTH),
      .PREFILL     (PRE)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .enable         (enable),
      .s_if           (sif.slave),
      .atten          (atten),
      .left_data      (left_data),
      .data_valid     (data_valid),
      .fifo_level     (fifo_level),
      .underrun_count (underrun_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic [15:0] m_q[$];
   logic [15:0] src_q[$];
   int          m_cnt;
   int          m_phase;
   logic [15:0] m_data;
   logic        m_valid;
   logic [15:0] m_urun;
   bit          hold;
   int          valid_pct;

   localparam int PH_IDLE = 0, PH_FILL = 1, PH_PLAY = 2;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Arithmetic right shift expressed as floor division by 2**a
   function automatic logic [15:0] atten_ref(input logic [15:0] x, input int a);
      int v = $signed(x);
      int d = 1 << a;
      int r = (v >= 0) ? v / d : -((-v + d - 1) / d);
      return r[15:0];
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_cnt   = 0;
      m_phase = PH_IDLE;
      m_data  = '0;
      m_valid = 1'b0;
      m_urun  = '0;
   endtask

   task automatic model_step();
      bit tick = (m_cnt == P - 1);
      bit push;
      int level = m_q.size();
      m_cnt = tick ? 0 : m_cnt + 1;
      if (!enable) begin
         m_q.delete();
         m_data  = '0;
         m_valid = 1'b0;
         m_phase = PH_IDLE;
         return;
      end
      push = sif.s_valid && (level != DEPTH);
      if (m_phase == PH_IDLE) begin
         m_phase = PH_FILL;
      end else if (m_phase == PH_FILL) begin
         if (tick) begin
            m_data  = '0;
            m_valid = 1'b0;
         end
         if (level >= PRE) m_phase = PH_PLAY;
      end else if (tick) begin
         if (level > 0) begin
            m_data  = atten_ref(m_q.pop_front(), int'(atten));
            m_valid = 1'b1;
         end else begin
            m_data  = '0;
            m_valid = 1'b0;
            if (m_urun != 16'hFFFF) m_urun++;
            m_phase = PH_FILL;
         end
      end
      if (push) begin
         m_q.push_back(sif.s_data);
         void'(src_q.pop_front());
         hold = 1'b0;
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      if (!hold) begin
         if (src_q.size() > 0 && $urandom_range(0, 99) < valid_pct) begin
            sif.s_valid = 1'b1;
            sif.s_data  = src_q[0];
            hold        = 1'b1;
         end else begin
            sif.s_valid = 1'b0;
         end
      end
      #1;
      check("s_ready", sif.s_ready, enable && (m_q.size() != DEPTH));
      @(posedge clk);
      model_step();
      #1;
      check("left_data", left_data, m_data);
      check("data_valid", data_valid, m_valid);
      check("fifo_level", fifo_level, m_q.size());
      check("underrun_count", underrun_count, m_urun);
   endtask

   task automatic run_until_valid(input string tag, input int budget);
      bit seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         cycle();
         seen = data_valid;
      end
      check(tag, seen, 1'b1);
   endtask

   initial begin
      bit seen;
      reset_n     = 1'b0;
      enable      = 1'b0;
      atten       = 4'd0;
      sif.s_valid = 1'b0;
      sif.s_data  = '0;
      hold        = 1'b0;
      valid_pct   = 100;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_left_data", left_data, 0);
      check("rst_data_valid", data_valid, 0);
      check("rst_fifo_level", fifo_level, 0);
      check("rst_underrun", underrun_count, 0);
      check("rst_s_ready", sif.s_ready, 0);
      reset_n = 1'b1;
      enable  = 1'b1;

      // Prefill with a ramp, then starve until the first underrun
      for (int i = 0; i < 32; i++) src_q.push_back(16'h1000 + 16'(i));
      run_until_valid("first_valid_timeout", 200);
      check("first_sample", left_data, 16'h1000);
      seen = 1'b0;
      for (int i = 0; i < 40 * P && !seen; i++) begin
         cycle();
         seen = (underrun_count != 0);
      end
      check("underrun_timeout", seen, 1'b1);
      check("underrun_count_1", underrun_count, 1);
      check("underrun_silent", {data_valid, left_data}, 17'h0);

      // Attenuation of extreme values, with atten wiggled mid-period
      src_q.push_back(16'h8000);
      src_q.push_back(16'h7FF0);
      for (int i = 0; i < 30; i++) src_q.push_back(16'($urandom));
      atten = 4'd4;
      run_until_valid("atten_valid_timeout", 300);
      check("atten_neg", left_data, 16'hF800);
      repeat (10) cycle();
      atten = 4'd9;
      repeat (10) cycle();
      check("atten_hold", left_data, 16'hF800);
      atten = 4'd4;
      repeat (12) cycle();
      check("atten_pos", left_data, 16'h07FF);

      // Overfill: held beat must survive until a pop frees a slot
      atten = 4'd0;
      for (int i = 0; i < 70; i++) src_q.push_back(16'($urandom));
      seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
         cycle();
         seen = (fifo_level == 7'd64);
      end
      check("full_timeout", seen, 1'b1);
      check("full_not_ready", sif.s_ready, 0);
      repeat (3 * P) cycle();

      // Disable while playing with a loaded FIFO
      enable = 1'b0;
      cycle();
      check("dis_level", fifo_level, 0);
      check("dis_valid", data_valid, 0);
      check("dis_ready", sif.s_ready, 0);
      check("dis_urun_kept", underrun_count, 1);
      enable = 1'b1;

      for (int c = 0; c < 6000; c++) begin
         if (c % 400 == 0) valid_pct = ($urandom_range(0, 2) == 0) ? 2 : int'($urandom_range(5, 100));
         if ($urandom_range(0, 49) == 0) atten = 4'($urandom);
         if ($urandom_range(0, 999) == 0) enable = 1'b0;
         else if (!enable && $urandom_range(0, 7) == 0) enable = 1'b1;
         if (src_q.size() < 4) src_q.push_back(16'($urandom));
         cycle();
      end

      // Asynchronous reset in the middle of a clock period
      enable = 1'b1;
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("arst_left_data", left_data, 0);
      check("arst_data_valid", data_valid, 0);
      check("arst_fifo_level", fifo_level, 0);
      check("arst_underrun", underrun_count, 0);
      model_reset();
      src_q.delete();
      hold        = 1'b0;
      sif.s_valid = 1'b0;
      valid_pct   = 100;
      @(posedge clk);
      #1 reset_n = 1'b1;
      for (int i = 0; i < 40; i++) src_q.push_back(16'($urandom));
      repeat (4 * P) cycle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
